// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
package uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCK    = 2'd1,
    ST_GAP     = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Index width for a requester vector; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, with wrap.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_any_c,
  output logic [IDX_W-1:0]   o_winner_c
);

  logic [IDX_W-1:0] w_idx;

  // Scan from farthest to nearest so the closest candidate overwrites.
  always_comb begin
    o_any_c    = |i_req;
    o_winner_c = '0;
    w_idx      = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % int'(NUM_REQ));
      if (i_req[w_idx]) o_winner_c = w_idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART TX FIFO write port.
// Optional idle-grant timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 360
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_uart_full,
  output logic                      o_uart_write,
  output logic [BYTE_W-1:0]         o_uart_data,
  output logic [2:0]                o_grant_id,
  output logic                      o_busy,
  output logic                      o_burst_trunc
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                      o_timeout_flag
`endif
);

  localparam int unsigned    IDX_W    = idx_width(NUM_REQ);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_grant, w_grant_nxt;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_burst_trunc, w_trunc_nxt;
  logic              r_uart_write, w_write_nxt;
  logic [BYTE_W-1:0] r_uart_data, w_data_nxt;

  logic              w_any_c;
  logic [IDX_W-1:0]  w_winner_c;
  logic [BYTE_W-1:0] w_lanes [NUM_REQ];
  logic              w_xfer;
  logic              w_sel_last;

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0]       r_to_cnt, w_to_cnt_nxt;
  logic              r_timeout_flag, w_to_flag_nxt;
`else
  logic              w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_lane
    assign w_lanes[i] = i_req_data[i*BYTE_W +: BYTE_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req      (i_req_valid),
    .i_ptr      (r_rr_ptr),
    .o_any_c    (w_any_c),
    .o_winner_c (w_winner_c)
  );

  assign w_xfer     = i_req_valid[r_grant] & ~i_uart_full;
  assign w_sel_last = i_req_last[r_grant];

  // Next-state, datapath next values and the combinational ready vector.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_count_nxt  = r_count;
    w_trunc_nxt  = r_burst_trunc;
    w_write_nxt  = 1'b0;
    w_data_nxt   = r_uart_data;
    o_req_ready  = '0;
`ifdef UART_ARB_TIMEOUT_EN
    w_to_cnt_nxt  = '0;
    w_to_flag_nxt = r_timeout_flag;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any_c) begin
          w_grant_nxt = w_winner_c;
          w_count_nxt = '0;
          w_state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        o_req_ready[r_grant] = ~i_uart_full;
`ifdef UART_ARB_TIMEOUT_EN
        w_to_cnt_nxt = r_to_cnt + 32'd1;
`endif
        if (w_xfer) begin
          w_write_nxt = 1'b1;
          w_data_nxt  = w_lanes[r_grant];
          w_count_nxt = r_count + CNT_W'(1);
`ifdef UART_ARB_TIMEOUT_EN
          w_to_cnt_nxt = '0;
`endif
          if (w_sel_last || (r_count == LAST_CNT)) begin
            w_state_nxt = ST_RELEASE;
            if (!w_sel_last) w_trunc_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_to_cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt   = ST_RELEASE;
          w_to_flag_nxt = 1'b1;
        end
`endif
      end
      ST_GAP: begin
        // Enforced idle cycle covers the one-cycle lag of the FIFO full flag.
        w_state_nxt = ST_LOCK;
`ifdef UART_ARB_TIMEOUT_EN
        w_to_cnt_nxt = r_to_cnt + 32'd1;
`endif
      end
      ST_RELEASE: begin
        w_rr_ptr_nxt = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_count       <= '0;
      r_burst_trunc <= 1'b0;
      r_uart_write  <= 1'b0;
      r_uart_data   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_count       <= w_count_nxt;
      r_burst_trunc <= w_trunc_nxt;
      r_uart_write  <= w_write_nxt;
      r_uart_data   <= w_data_nxt;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt       <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_to_cnt       <= w_to_cnt_nxt;
      r_timeout_flag <= w_to_flag_nxt;
    end
  end

  assign o_timeout_flag = r_timeout_flag;
`endif

  assign o_uart_write  = r_uart_write;
  assign o_uart_data   = r_uart_data;
  assign o_grant_id    = 3'(r_grant);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_burst_trunc = r_burst_trunc;

endmodule
